// File: rtl/paramul_pkg.sv
// paramul_pkg: shared types and constants for the multiplier datapath.
// Consumed by dot_accum and its requantize sub-block.
package paramul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    ROUND,
    HOLD
  } acc_state_e;

  localparam int PROD_W = 64;
  localparam int RES_W  = 32;

  localparam logic signed [63:0] SAT_S_MAX = 64'sd2147483647;
  localparam logic signed [63:0] SAT_S_MIN = -64'sd2147483648;
  localparam logic signed [63:0] SAT_U_MAX = 64'sd4294967295;
  localparam logic signed [63:0] SAT_U_MIN = 64'sd0;

endpackage

// File: rtl/dot_accum_if.sv
// dot_accum_if: product-in / result-out handshake bundle.
// slave = accumulator side, master = producer/consumer side.
interface dot_accum_if;
  import paramul_pkg::*;

  logic [PROD_W-1:0] prod;
  logic              prod_sign;
  logic              prod_valid;
  logic              prod_last;
  logic              prod_ready;
  logic [RES_W-1:0]  bias;
  logic [RES_W-1:0]  res;
  logic              res_valid;
  logic              res_ready;
  logic              res_sat;
  logic              res_len_err;

  modport slave (
    input  prod,
    input  prod_sign,
    input  prod_valid,
    input  prod_last,
    input  bias,
    input  res_ready,
    output prod_ready,
    output res,
    output res_valid,
    output res_sat,
    output res_len_err
  );

  modport master (
    output prod,
    output prod_sign,
    output prod_valid,
    output prod_last,
    output bias,
    output res_ready,
    input  prod_ready,
    input  res,
    input  res_valid,
    input  res_sat,
    input  res_len_err
  );

endinterface

// File: rtl/dot_accum_round_sat.sv
// dot_accum_round_sat: wide accumulator -> rounded, saturated 32-bit result.
// Purely combinational; round half toward +inf, then clamp.
module dot_accum_round_sat
  import paramul_pkg::*;
#(
  parameter int ACC_W     = 72,
  parameter int FRAC_BITS = 16
) (
  input  logic [ACC_W-1:0] acc,
  input  logic             sign,
  output logic [RES_W-1:0] res,
  output logic             sat
);

  // Two guard bits: rounding carry plus a clean sign bit for unsigned sums.
  localparam int W = ACC_W + 2;

  localparam logic signed [W-1:0] S_MAX = W'(SAT_S_MAX);
  localparam logic signed [W-1:0] S_MIN = W'(SAT_S_MIN);
  localparam logic signed [W-1:0] U_MAX = W'(SAT_U_MAX);
  localparam logic signed [W-1:0] U_MIN = W'(SAT_U_MIN);
  localparam logic [W-1:0]        HALF  = (W'(1) << FRAC_BITS) >> 1;

  logic [W-1:0]        wide;
  logic [W-1:0]        sum;
  logic signed [W-1:0] q;

  always_comb begin
    wide = {{2{sign & acc[ACC_W-1]}}, acc};
    sum  = wide + HALF;
    if (sign) begin
      q = $signed(sum) >>> FRAC_BITS;
    end else begin
      q = $signed(sum >> FRAC_BITS);
    end
    res = q[RES_W-1:0];
    sat = 1'b0;
    if (sign) begin
      if (q > S_MAX) begin
        res = S_MAX[RES_W-1:0];
        sat = 1'b1;
      end else if (q < S_MIN) begin
        res = S_MIN[RES_W-1:0];
        sat = 1'b1;
      end
    end else begin
      if (q > U_MAX) begin
        res = U_MAX[RES_W-1:0];
        sat = 1'b1;
      end else if (q < U_MIN) begin
        res = U_MIN[RES_W-1:0];
        sat = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dot_accum.sv
// dot_accum: vector accumulate, round and saturate stage after the multiplier.
// Optional bias term on the first beat: define DOT_ACCUM_BIAS_EN.
module dot_accum
  import paramul_pkg::*;
#(
  parameter int ACC_W     = 72,
  parameter int FRAC_BITS = 16,
  parameter int MAX_LEN   = 256
) (
  input logic       clk,
  input logic       rst_n,
  dot_accum_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LEN - 1);

  acc_state_e       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             sign_q;
  logic             len_err;

  logic             ready_q;
  logic [RES_W-1:0] res_q;
  logic             valid_q;
  logic             sat_q;
  logic             len_q;

  logic             accept;
  logic             ext_sign;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] first_term;
  logic [RES_W-1:0] rs_res;
  logic             rs_sat;

  assign accept   = bus.prod_valid & ready_q;
  assign ext_sign = (state == IDLE) ? bus.prod_sign : sign_q;
  assign prod_ext = {{(ACC_W-PROD_W){ext_sign & bus.prod[PROD_W-1]}},
                     bus.prod};

`ifdef DOT_ACCUM_BIAS_EN
  logic [ACC_W-1:0] bias_ext;
  assign bias_ext = {{(ACC_W-RES_W){bus.prod_sign & bus.bias[RES_W-1]}},
                     bus.bias};
  assign first_term = prod_ext + (bias_ext << FRAC_BITS);
`else
  logic unused_bias;
  assign unused_bias = ^bus.bias;
  assign first_term  = prod_ext;
`endif

  dot_accum_round_sat #(
    .ACC_W     (ACC_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_round_sat (
    .acc  (acc),
    .sign (sign_q),
    .res  (rs_res),
    .sat  (rs_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      count   <= '0;
      sign_q  <= 1'b0;
      len_err <= 1'b0;
      ready_q <= 1'b0;
      res_q   <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
      len_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            sign_q <= bus.prod_sign;
            acc    <= first_term;
            count  <= CNT_W'(1);
            if (bus.prod_last) begin
              state   <= ROUND;
              ready_q <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc   <= acc + prod_ext;
            count <= count + CNT_W'(1);
            // Force-close a runaway vector at MAX_LEN and flag it.
            if (bus.prod_last || count == LAST_CNT) begin
              state   <= ROUND;
              ready_q <= 1'b0;
              len_err <= ~bus.prod_last;
            end
          end
        end
        ROUND: begin
          res_q   <= rs_res;
          sat_q   <= rs_sat;
          len_q   <= len_err;
          valid_q <= 1'b1;
          state   <= HOLD;
        end
        HOLD: begin
          if (bus.res_ready) begin
            valid_q <= 1'b0;
            acc     <= '0;
            count   <= '0;
            len_err <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.prod_ready  = ready_q;
  assign bus.res         = res_q;
  assign bus.res_valid   = valid_q;
  assign bus.res_sat     = sat_q;
  assign bus.res_len_err = len_q;

endmodule
